// File: rtl/rv32i_pkg.sv
// Shared constants for the input I/O page: register offsets, button count,
// register selector type and the address decode helper.
package rv32i_pkg;

  localparam logic [11:0] IO_IN_SW_OFS      = 12'h000;
  localparam logic [11:0] IO_IN_BTN_LVL_OFS = 12'h004;
  localparam logic [11:0] IO_IN_BTN_EVT_OFS = 12'h008;
  localparam logic [11:0] IO_IN_IRQ_EN_OFS  = 12'h00C;
  localparam logic [11:0] IO_IN_DB_CFG_OFS  = 12'h010;

  localparam int IO_IN_NUM_BTN = 4;

  typedef enum logic [2:0] {
    REG_SW,
    REG_BTN_LVL,
    REG_BTN_EVT,
    REG_IRQ_EN,
    REG_DB_CFG,
    REG_NONE
  } io_in_reg_e;

  // Word index (byte offset bits [11:2]) to register selector.
  function automatic io_in_reg_e io_in_decode(input logic [9:0] word_idx);
    io_in_reg_e sel;
    sel = REG_NONE;
    if (word_idx == IO_IN_SW_OFS[11:2])      sel = REG_SW;
    if (word_idx == IO_IN_BTN_LVL_OFS[11:2]) sel = REG_BTN_LVL;
    if (word_idx == IO_IN_BTN_EVT_OFS[11:2]) sel = REG_BTN_EVT;
    if (word_idx == IO_IN_IRQ_EN_OFS[11:2])  sel = REG_IRQ_EN;
    if (word_idx == IO_IN_DB_CFG_OFS[11:2])  sel = REG_DB_CFG;
    return sel;
  endfunction

endpackage

// File: rtl/io_input_ctrl_if.sv
// LSU-side load/store bus of the input peripheral.
interface io_input_ctrl_if;

  logic [11:0] i_addr;
  logic        i_rd_en;
  logic        i_wr_en;
  logic [31:0] i_wr_data;
  logic [31:0] o_rd_data;
  logic        o_rd_vld;

  modport master (
    output i_addr, i_rd_en, i_wr_en, i_wr_data,
    input  o_rd_data, o_rd_vld
  );

  modport slave (
    input  i_addr, i_rd_en, i_wr_en, i_wr_data,
    output o_rd_data, o_rd_vld
  );

endinterface

// File: rtl/btn_debounce.sv
// Single-button debouncer: a new level is accepted only after it has been
// seen on the synchronized input for DEBOUNCE_CYCLES consecutive edges.
// The press/release pulses are high during the cycle whose edge updates level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sync,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  assign differ  = (i_sync != level);
  assign accept  = differ && (cnt == CNT_LAST);
  assign o_level = level;
  assign o_rise  = accept &  i_sync;
  assign o_fall  = accept & ~i_sync;

  // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge values.
      level <= i_sync;
      cnt   <= '0;
    end else if (differ) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/io_input_ctrl.sv
// Memory-mapped input peripheral: synchronizes switches and buttons,
// debounces buttons, keeps sticky press/release flags and raises an IRQ.
module io_input_ctrl
  import rv32i_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [31:0]              i_io_sw,
  input  logic [IO_IN_NUM_BTN-1:0] i_io_btn,
  io_input_ctrl_if.slave           bus,
  output logic                     o_irq
);

  localparam int EVT_W = 2 * IO_IN_NUM_BTN;

  logic [31:0]              sw_s1, sw_s2;
  logic [IO_IN_NUM_BTN-1:0] btn_s1, btn_s2;
  logic [IO_IN_NUM_BTN-1:0] level, rise, fall;
  logic [EVT_W-1:0]         btn_evt, irq_en, evt_clr;
  logic [31:0]              rd_mux;
  io_in_reg_e               sel;
  logic                     unused_bits;

  assign sel         = io_in_decode(bus.i_addr[11:2]);
  assign evt_clr     = (bus.i_wr_en && sel == REG_BTN_EVT) ? bus.i_wr_data[EVT_W-1:0] : '0;
  assign unused_bits = ^{bus.i_addr[1:0], bus.i_wr_data[31:EVT_W]};

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= i_io_sw;
      sw_s2  <= sw_s1;
      btn_s1 <= i_io_btn;
      btn_s2 <= btn_s1;
    end
  end

  for (genvar g = 0; g < IO_IN_NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_sync (btn_s2[g]),
      .o_level(level[g]),
      .o_rise (rise[g]),
      .o_fall (fall[g])
    );
  end

  // Sticky event flags (set beats write-1-to-clear) and the IRQ mask.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_evt <= '0;
      irq_en  <= '0;
    end else begin
      btn_evt <= (btn_evt & ~evt_clr) | {fall, rise};
      if (bus.i_wr_en && sel == REG_IRQ_EN) irq_en <= bus.i_wr_data[EVT_W-1:0];
    end
  end

  // Read mux over current (pre-write) register values.
  always_comb begin
    // NOTE: default first so no path through the case leaves rd_mux unassigned.
    rd_mux = '0;
    case (sel)
      REG_SW:      rd_mux = sw_s2;
      REG_BTN_LVL: rd_mux = 32'(level);
      REG_BTN_EVT: rd_mux = 32'(btn_evt);
      REG_IRQ_EN:  rd_mux = 32'(irq_en);
      REG_DB_CFG:  rd_mux = 32'(DEBOUNCE_CYCLES);
      default:     rd_mux = '0;
    endcase
  end

  // Registered read response and interrupt request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_rd_data <= '0;
      bus.o_rd_vld  <= 1'b0;
      o_irq         <= 1'b0;
    end else begin
      if (bus.i_rd_en) bus.o_rd_data <= rd_mux;
      bus.o_rd_vld <= bus.i_rd_en;
      o_irq        <= |(btn_evt & irq_en);
    end
  end

endmodule

// File: tb/tb_io_input_ctrl.sv
// Self-checking bench for io_input_ctrl with DEBOUNCE_CYCLES = 4.
// Reads push their expected data to a scoreboard queue; a monitor pops and
// compares whenever o_rd_vld is seen.
module tb_io_input_ctrl;
  import rv32i_pkg::*;

  localparam int DB = 4;

  typedef struct {
    logic [31:0] data;
    string       name;
  } sb_t;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] sw;
  logic [3:0]  btn;
  logic        irq;
  int          checks = 0;
  int          errors = 0;
  sb_t         sb[$];
  vec_t        vecs[12];

  io_input_ctrl_if bus ();

  io_input_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_io_sw (sw),
    .i_io_btn(btn),
    .bus     (bus.slave),
    .o_irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: inputs change at the falling edge and are sampled at the next rising edge.
  task automatic cyc(input string name, input logic rd, input logic wr,
                     input logic [11:0] addr, input logic [31:0] wd, input logic [31:0] exp);
    sb_t e;
    @(negedge clk);
    bus.i_rd_en   = rd;
    bus.i_wr_en   = wr;
    bus.i_addr    = addr;
    bus.i_wr_data = wd;
    if (rd) begin
      e.data = exp;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc("idle", 1'b0, 1'b0, 12'h000, 32'h0, 32'h0);
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
    cyc(name, 1'b1, 1'b0, addr, 32'h0, exp);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] wd);
    cyc("wr", 1'b0, 1'b1, addr, wd, 32'h0);
  endtask

  // Scoreboard monitor, sampling 2 time units after each rising edge.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #2;
      if (bus.o_rd_vld) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_rd_vld: got 1 expected 0");
        end else begin
          e = sb.pop_front();
          check(e.name, bus.o_rd_data, e.data);
        end
      end else if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: got no o_rd_vld expected %h", e.name, e.data);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    sw = '0;
    btn = '0;
    bus.i_rd_en = 1'b0;
    bus.i_wr_en = 1'b0;
    bus.i_addr = '0;
    bus.i_wr_data = '0;

    // Reset state
    idle(3);
    check("rst_rd_vld", 32'(bus.o_rd_vld), 32'h0);
    check("rst_rd_data", bus.o_rd_data, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    rd("db_cfg_after_rst", IO_IN_DB_CFG_OFS, 32'd4);

    // Switch latency: raw change at edge 0, readable from edge 2
    idle(1);
    sw = 32'hA5A5_0F0F;
    rd("sw_edge1_old", IO_IN_SW_OFS, 32'h0);
    rd("sw_edge2_new", IO_IN_SW_OFS, 32'hA5A5_0F0F);

    // Table of register-map accesses
    vecs[0]  = '{"irq_en_rd_pre_write", 1'b1, 1'b1, 12'h00C, 32'hFFFF_FF5A, 32'h0};
    vecs[1]  = '{"irq_en_rd",           1'b1, 1'b0, 12'h00C, 32'h0,         32'h5A};
    vecs[2]  = '{"irq_en_low_bits_ign", 1'b1, 1'b0, 12'h00E, 32'h0,         32'h5A};
    vecs[3]  = '{"db_cfg_wr_ign",       1'b0, 1'b1, 12'h010, 32'h1234,      32'h0};
    vecs[4]  = '{"db_cfg_rd",           1'b1, 1'b0, 12'h010, 32'h0,         32'd4};
    vecs[5]  = '{"lvl_wr_ign",          1'b0, 1'b1, 12'h004, 32'hF,         32'h0};
    vecs[6]  = '{"lvl_rd",              1'b1, 1'b0, 12'h004, 32'h0,         32'h0};
    vecs[7]  = '{"evt_rd",              1'b1, 1'b0, 12'h008, 32'h0,         32'h0};
    vecs[8]  = '{"unmapped_014",        1'b1, 1'b0, 12'h014, 32'h0,         32'h0};
    vecs[9]  = '{"unmapped_ffc",        1'b1, 1'b0, 12'hFFC, 32'h0,         32'h0};
    vecs[10] = '{"sw_wr_ign_rd",        1'b1, 1'b1, 12'h000, 32'h0,         32'hA5A5_0F0F};
    vecs[11] = '{"irq_en_clr_rd",       1'b1, 1'b1, 12'h00C, 32'h0,         32'h5A};
    for (int i = 0; i < 12; i++)
      cyc(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    rd("irq_en_zero", IO_IN_IRQ_EN_OFS, 32'h0);
    rd("sw_after_wr", IO_IN_SW_OFS, 32'hA5A5_0F0F);

    // Btn0 press: level/event at edge 5, irq at edge 6
    wr(IO_IN_IRQ_EN_OFS, 32'h01);
    idle(1);
    btn = 4'b0001;
    idle(4);
    rd("btn0_lvl_edge5", IO_IN_BTN_LVL_OFS, 32'h0);
    rd("btn0_evt_edge6", IO_IN_BTN_EVT_OFS, 32'h01);
    check("btn0_irq_before_edge6", 32'(irq), 32'h0);
    rd("btn0_lvl_edge7", IO_IN_BTN_LVL_OFS, 32'h1);
    check("btn0_irq_after_edge6", 32'(irq), 32'h1);
    btn = 4'b0000;
    idle(8);
    rd("btn0_release_evt", IO_IN_BTN_EVT_OFS, 32'h11);
    rd("btn0_release_lvl", IO_IN_BTN_LVL_OFS, 32'h0);
    wr(IO_IN_BTN_EVT_OFS, 32'h10);
    rd("evt_w1c_partial", IO_IN_BTN_EVT_OFS, 32'h01);

    // Btn2 glitch of 3 cycles is rejected
    btn = 4'b0100;
    idle(3);
    btn = 4'b0000;
    idle(8);
    rd("glitch_lvl", IO_IN_BTN_LVL_OFS, 32'h0);
    rd("glitch_evt", IO_IN_BTN_EVT_OFS, 32'h01);

    // Btn2 pulse of exactly DB cycles is accepted
    btn = 4'b0100;
    idle(4);
    btn = 4'b0000;
    idle(12);
    rd("pulse4_evt", IO_IN_BTN_EVT_OFS, 32'h45);
    rd("pulse4_lvl", IO_IN_BTN_LVL_OFS, 32'h0);
    wr(IO_IN_BTN_EVT_OFS, 32'h44);
    rd("pulse4_evt_clr", IO_IN_BTN_EVT_OFS, 32'h01);
    check("irq_bit0_masked_in", 32'(irq), 32'h1);

    // Clear of bit0 in the same cycle btn1's press fires
    idle(1);
    btn = 4'b0010;
    idle(4);
    wr(IO_IN_BTN_EVT_OFS, 32'h01);
    rd("set_clr_same_cycle", IO_IN_BTN_EVT_OFS, 32'h02);
    idle(1);
    check("irq_follows_mask_off", 32'(irq), 32'h0);
    wr(IO_IN_IRQ_EN_OFS, 32'h02);
    idle(2);
    check("irq_follows_mask_on", 32'(irq), 32'h1);

    // Back-to-back reads around a write to read-only SW
    rd("b2b_unmapped_020", 12'h020, 32'h0);
    rd("b2b_lvl", IO_IN_BTN_LVL_OFS, 32'h2);
    wr(IO_IN_SW_OFS, 32'hFFFF_FFFF);
    rd("b2b_sw_unchanged", IO_IN_SW_OFS, 32'hA5A5_0F0F);

    // Asynchronous reset mid-cycle, button held through reset
    rd("sw_before_rst", IO_IN_SW_OFS, 32'hA5A5_0F0F);
    @(posedge clk);
    #3;
    check("vld_before_rst", 32'(bus.o_rd_vld), 32'h1);
    check("irq_before_rst", 32'(irq), 32'h1);
    rst_n = 1'b0;
    btn = 4'b0001;
    #1;
    check("async_rst_rd_vld", 32'(bus.o_rd_vld), 32'h0);
    check("async_rst_rd_data", bus.o_rd_data, 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(4);
    rd("held_lvl_edge5", IO_IN_BTN_LVL_OFS, 32'h0);
    rd("held_lvl_edge6", IO_IN_BTN_LVL_OFS, 32'h1);
    rd("db_cfg_post_rst", IO_IN_DB_CFG_OFS, 32'd4);
    rd("irq_en_post_rst", IO_IN_IRQ_EN_OFS, 32'h0);
    rd("held_evt", IO_IN_BTN_EVT_OFS, 32'h01);
    idle(2);
    check("rd_data_hold", bus.o_rd_data, 32'h01);
    check("irq_masked_post_rst", 32'(irq), 32'h0);

    btn = 4'b0000;
    idle(3);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
